// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: frame sequencer around the FIR core's pull interface.
// Buffers upstream samples, answers FIR `next` requests, raises `stop`
// after the programmed frame length, and queues FIR results for a
// downstream valid/ready consumer.
// Optional watchdog: define FIR_STREAM_CTRL_TIMEOUT_EN to add err_timeout.
module fir_stream_ctrl #(
   parameter int DATA_W    = 32,
   parameter int IN_DEPTH  = 16,
   parameter int OUT_DEPTH = 16,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  frame_len,
   output logic              busy,
   output logic              done,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              fir_rst,
   output logic [DATA_W-1:0] fir_in,
   input  logic              fir_next,
   input  logic [DATA_W-1:0] fir_out,
   input  logic              fir_ready,
   output logic              fir_stop,
   output logic              err_underrun,
   output logic              err_overflow,
   output logic              err_extra
`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
   ,
   output logic              err_timeout
`endif
);

   localparam int IW = $clog2(IN_DEPTH);
   localparam int OW = $clog2(OUT_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_FIRRST, S_RUN, S_DRAIN, S_DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] in_mem  [IN_DEPTH];
   logic [DATA_W-1:0] out_mem [OUT_DEPTH];
   logic [IW-1:0]     in_wr, in_rd;
   logic [IW:0]       in_level;
   logic [OW-1:0]     out_wr, out_rd;
   logic [OW:0]       out_level;
   logic [CNT_W-1:0]  len_q, in_cnt, out_cnt;

   logic in_full, in_empty, out_full, out_empty;
   logic in_push, in_pop, out_push, m_pop;
   logic start_acc, feed_req, stop_req, ready_acc, active, timeout_hit;

   assign in_full   = (in_level == (IW+1)'(IN_DEPTH));
   assign in_empty  = (in_level == '0);
   assign out_full  = (out_level == (OW+1)'(OUT_DEPTH));
   assign out_empty = (out_level == '0);

   assign s_ready = !in_full;
   assign m_valid = !out_empty;
   assign m_data  = out_empty ? '0 : out_mem[out_rd];

   assign active    = (state == S_RUN) || (state == S_DRAIN);
   assign start_acc = start && (state == S_IDLE);
   assign feed_req  = (state == S_RUN) && fir_next && (in_cnt < len_q);
   assign stop_req  = (state == S_RUN) && fir_next && (in_cnt == len_q);
   assign ready_acc = fir_ready && active && (out_cnt < len_q);

   assign in_push  = s_valid && !in_full;
   assign in_pop   = feed_req && !in_empty;
   assign m_pop    = m_ready && !out_empty;
   // A pop frees the slot on the same edge, so a full FIFO being drained still accepts.
   assign out_push = ready_acc && (!out_full || m_pop);

`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wd_cnt;

   assign timeout_hit = active && (wd_cnt == WDW'(TIMEOUT - 1));

   // Watchdog: counts cycles without FIR output while the FIR is running.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt      <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (start_acc)
            err_timeout <= 1'b0;
         if (state == S_FIRRST || fir_ready)
            wd_cnt <= '0;
         else if (active && !timeout_hit)
            wd_cnt <= wd_cnt + 1'b1;
         if (timeout_hit)
            err_timeout <= 1'b1;
      end
   end
`else
   // No watchdog: the controller waits for the FIR indefinitely.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM next state and state-decoded outputs.
   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      fir_rst   = 1'b1;
      unique case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start_acc)
               state_nxt = (frame_len == '0) ? S_DONE : S_FIRRST;
         end
         S_FIRRST: state_nxt = S_RUN;
         S_RUN: begin
            fir_rst = 1'b0;
            if (timeout_hit)   state_nxt = S_DONE;
            else if (stop_req) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            fir_rst = 1'b0;
            if (timeout_hit)
               state_nxt = S_DONE;
            else if (out_cnt == len_q || (ready_acc && (out_cnt + 1'b1) == len_q))
               state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // FIFO storage writes (data only, never reset).
   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wr]   <= s_data;
      if (out_push) out_mem[out_wr] <= fir_out;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_wr     <= '0;
         in_rd     <= '0;
         in_level  <= '0;
         out_wr    <= '0;
         out_rd    <= '0;
         out_level <= '0;
      end else begin
         if (in_push)  in_wr  <= in_wr + 1'b1;
         if (in_pop)   in_rd  <= in_rd + 1'b1;
         if (out_push) out_wr <= out_wr + 1'b1;
         if (m_pop)    out_rd <= out_rd + 1'b1;
         unique case ({in_push, in_pop})
            2'b10:   in_level <= in_level + 1'b1;
            2'b01:   in_level <= in_level - 1'b1;
            default: in_level <= in_level;
         endcase
         unique case ({out_push, m_pop})
            2'b10:   out_level <= out_level + 1'b1;
            2'b01:   out_level <= out_level - 1'b1;
            default: out_level <= out_level;
         endcase
      end
   end

   // Frame counters, FIR input register, stop line and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q        <= '0;
         in_cnt       <= '0;
         out_cnt      <= '0;
         fir_in       <= '0;
         fir_stop     <= 1'b0;
         err_underrun <= 1'b0;
         err_overflow <= 1'b0;
         err_extra    <= 1'b0;
      end else begin
         if (start_acc) begin
            len_q        <= frame_len;
            in_cnt       <= '0;
            out_cnt      <= '0;
            err_underrun <= 1'b0;
            err_overflow <= 1'b0;
            err_extra    <= 1'b0;
         end
         if (feed_req) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_empty) begin
               fir_in       <= '0;
               err_underrun <= 1'b1;
            end else begin
               fir_in <= in_mem[in_rd];
            end
         end
         if (stop_req)
            fir_stop <= 1'b1;
         if (state == S_DONE)
            fir_stop <= 1'b0;
         if (ready_acc) begin
            out_cnt <= out_cnt + 1'b1;
            if (!out_push)
               err_overflow <= 1'b1;
         end
         if (fir_ready && !ready_acc)
            err_extra <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: scenario bench with a behavioural FIR pull model and
// scoreboard queues for fir_in and m_data.
module tb_fir_stream_ctrl;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   logic              clk, rst, start;
   logic [CNT_W-1:0]  frame_len;
   logic              busy, done;
   logic [DATA_W-1:0] s_data;
   logic              s_valid, s_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_valid, m_ready;
   logic              fir_rst;
   logic [DATA_W-1:0] fir_in;
   logic              fir_next;
   logic [DATA_W-1:0] fir_out;
   logic              fir_ready, fir_stop;
   logic              err_underrun, err_overflow, err_extra;
`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
   logic              err_timeout;
`endif

   int total = 0;
   int bad   = 0;

   logic [DATA_W-1:0] exp_in[$], obs_in[$], exp_out[$], obs_out[$];

   fir_stream_ctrl #(
      .DATA_W(DATA_W), .IN_DEPTH(16), .OUT_DEPTH(4), .CNT_W(CNT_W), .TIMEOUT(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
      .busy(busy), .done(done),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .fir_rst(fir_rst), .fir_in(fir_in), .fir_next(fir_next),
      .fir_out(fir_out), .fir_ready(fir_ready), .fir_stop(fir_stop),
      .err_underrun(err_underrun), .err_overflow(err_overflow), .err_extra(err_extra)
`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
      , .err_timeout(err_timeout)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic push_sample(input logic [DATA_W-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      exp_in.push_back(v);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   // Behavioural FIR: one request every other cycle while out of reset and
   // not stopped; optionally emits the negated input one cycle after it lands.
   task automatic fir_frame(input int len, input bit emit, input int max_cyc, input int tail,
                            output int stop_at, output int done_cnt,
                            output int run_at, output int done_at);
      int  nexts, tail_left;
      bit  pend, done_seen;
      nexts = 0; pend = 0; done_seen = 0; tail_left = tail;
      stop_at = -1; done_cnt = 0; run_at = -1; done_at = -1;
      obs_in.delete();
      obs_out.delete();
      start = 1'b1;
      frame_len = CNT_W'(len);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         fir_next  = 1'b0;
         fir_ready = 1'b0;
         if (!fir_rst && run_at < 0) run_at = c;
         if (done) begin
            done_cnt++;
            done_seen = 1;
            if (done_at < 0) done_at = c;
         end
         if (fir_stop && stop_at < 0) stop_at = nexts;
         if (m_valid && m_ready) obs_out.push_back(m_data);
         if (pend) begin
            obs_in.push_back(fir_in);
            if (emit) begin
               fir_ready = 1'b1;
               fir_out   = fir_in ^ 32'h8000_0000;
               exp_out.push_back(fir_out);
            end
            pend = 0;
         end else if (!fir_rst && !fir_stop && nexts <= len) begin
            fir_next = 1'b1;
            nexts++;
            if (nexts <= len) pend = 1;
         end
         if (done_seen) begin
            if (tail_left == 0) break;
            tail_left--;
         end
         @(posedge clk); #1;
      end
      fir_next  = 1'b0;
      fir_ready = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL reset_fir_rst got=%b want=1", fir_rst); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++; if (fir_stop !== 1'b0) begin bad++; $display("FAIL reset_fir_stop got=%b want=0", fir_stop); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
      total++; if (fir_in !== 32'h0) begin bad++; $display("FAIL reset_fir_in got=%h want=0", fir_in); end
      total++; if ({err_underrun, err_overflow, err_extra} !== 3'b000) begin
         bad++; $display("FAIL reset_errs got=%b want=000", {err_underrun, err_overflow, err_extra}); end
   endtask

   task automatic test_basic();
      int stop_at, done_cnt, run_at, done_at;
      exp_in.delete(); exp_out.delete();
      push_sample(32'h3F80_0000);
      push_sample(32'h4000_0000);
      push_sample(32'h4040_0000);
      push_sample(32'h4080_0000);
      m_ready = 1'b1;
      fir_frame(4, 1'b1, 80, 8, stop_at, done_cnt, run_at, done_at);
      total++; if (obs_in.size() != 4) begin bad++; $display("FAIL basic_in_count got=%0d want=4", obs_in.size()); end
      for (int i = 0; i < exp_in.size(); i++) begin
         total++;
         if (i >= obs_in.size() || obs_in[i] !== exp_in[i]) begin
            bad++; $display("FAIL basic_fir_in[%0d] got=%h want=%h", i, (i < obs_in.size()) ? obs_in[i] : 'x, exp_in[i]);
         end
      end
      total++; if (stop_at != 5) begin bad++; $display("FAIL basic_stop_after got=%0d want=5", stop_at); end
      total++; if (obs_out.size() != 4) begin bad++; $display("FAIL basic_out_count got=%0d want=4", obs_out.size()); end
      for (int i = 0; i < exp_out.size(); i++) begin
         total++;
         if (i >= obs_out.size() || obs_out[i] !== exp_out[i]) begin
            bad++; $display("FAIL basic_m_data[%0d] got=%h want=%h", i, (i < obs_out.size()) ? obs_out[i] : 'x, exp_out[i]);
         end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
      total++; if ({err_underrun, err_overflow, err_extra} !== 3'b000) begin
         bad++; $display("FAIL basic_errs got=%b want=000", {err_underrun, err_overflow, err_extra}); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_underrun();
      int stop_at, done_cnt, run_at, done_at;
      exp_in.delete(); exp_out.delete();
      push_sample(32'h3F80_0000);
      exp_in.push_back(32'h0);
      exp_in.push_back(32'h0);
      m_ready = 1'b1;
      fir_frame(3, 1'b1, 80, 8, stop_at, done_cnt, run_at, done_at);
      for (int i = 0; i < exp_in.size(); i++) begin
         total++;
         if (i >= obs_in.size() || obs_in[i] !== exp_in[i]) begin
            bad++; $display("FAIL under_fir_in[%0d] got=%h want=%h", i, (i < obs_in.size()) ? obs_in[i] : 'x, exp_in[i]);
         end
      end
      total++; if (err_underrun !== 1'b1) begin bad++; $display("FAIL under_flag got=%b want=1", err_underrun); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL under_done_pulses got=%0d want=1", done_cnt); end
      total++; if (obs_out.size() != exp_out.size()) begin
         bad++; $display("FAIL under_out_count got=%0d want=%0d", obs_out.size(), exp_out.size()); end
   endtask

   task automatic test_overflow();
      int stop_at, done_cnt, run_at, done_at;
      exp_in.delete(); exp_out.delete();
      for (int i = 0; i < 6; i++) push_sample(32'h4100_0000 + 32'(i));
      m_ready = 1'b0;
      fir_frame(6, 1'b1, 100, 2, stop_at, done_cnt, run_at, done_at);
      total++; if (done_cnt != 1) begin bad++; $display("FAIL ovf_done_pulses got=%0d want=1", done_cnt); end
      total++; if (err_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", err_overflow); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL ovf_m_valid got=%b want=1", m_valid); end
      total++; if (stop_at != 7) begin bad++; $display("FAIL ovf_stop_after got=%0d want=7", stop_at); end
      total++; if (err_underrun !== 1'b0) begin bad++; $display("FAIL ovf_underrun got=%b want=0", err_underrun); end
   endtask

   task automatic test_extra();
      fir_ready = 1'b1;
      fir_out   = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      fir_ready = 1'b0;
      total++; if (err_extra !== 1'b1) begin bad++; $display("FAIL extra_flag got=%b want=1", err_extra); end
      obs_out.delete();
      m_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (m_valid) obs_out.push_back(m_data);
         @(posedge clk); #1;
      end
      total++; if (obs_out.size() != 4) begin bad++; $display("FAIL extra_fifo_count got=%0d want=4", obs_out.size()); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= obs_out.size() || obs_out[i] !== exp_out[i]) begin
            bad++; $display("FAIL extra_m_data[%0d] got=%h want=%h", i, (i < obs_out.size()) ? obs_out[i] : 'x, exp_out[i]);
         end
      end
      start = 1'b1;
      frame_len = '0;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (err_extra !== 1'b0) begin bad++; $display("FAIL extra_cleared got=%b want=0", err_extra); end
      total++; if (err_overflow !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b want=0", err_overflow); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_len_done got=%b want=1", done); end
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_len_idle got=%b want=0", busy); end
   endtask

   task automatic test_mid_reset();
      int waited, dones;
      exp_in.delete();
      for (int i = 0; i < 4; i++) push_sample(32'h4200_0000 + 32'(i));
      m_ready = 1'b0;
      start = 1'b1;
      frame_len = CNT_W'(4);
      @(posedge clk); #1;
      start = 1'b0;
      waited = 0;
      while (fir_rst && waited < 10) begin @(posedge clk); #1; waited++; end
      total++; if (fir_rst !== 1'b0) begin bad++; $display("FAIL mid_enter_run got=%b want=0", fir_rst); end
      fir_next = 1'b1;
      @(posedge clk); #1;
      fir_next = 1'b0; fir_ready = 1'b1; fir_out = 32'h1234_5678;
      @(posedge clk); #1;
      fir_ready = 1'b0; fir_next = 1'b1;
      @(posedge clk); #1;
      fir_next = 1'b0;
      total++; if (fir_in !== exp_in[1]) begin bad++; $display("FAIL mid_fir_in got=%h want=%h", fir_in, exp_in[1]); end
      total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_m_valid got=%b want=1", m_valid); end
      #3 rst = 1'b1;
      #1;
      total++; if (fir_rst !== 1'b1) begin bad++; $display("FAIL mid_fir_rst got=%b want=1", fir_rst); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
      total++; if (fir_stop !== 1'b0) begin bad++; $display("FAIL mid_fir_stop got=%b want=0", fir_stop); end
      total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got=%b want=0", m_valid); end
      total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL mid_s_ready got=%b want=1", s_ready); end
      dones = 0;
      for (int c = 0; c < 3; c++) begin
         if (done) dones++;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (done) dones++;
         @(posedge clk); #1;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", dones); end
   endtask

   task automatic test_timeout();
      int stop_at, done_cnt, run_at, done_at;
      exp_in.delete(); exp_out.delete();
      push_sample(32'h3F80_0000);
      push_sample(32'h4000_0000);
      m_ready = 1'b1;
      fir_frame(2, 1'b0, 40, 2, stop_at, done_cnt, run_at, done_at);
`ifdef FIR_STREAM_CTRL_TIMEOUT_EN
      total++; if (done_cnt != 1) begin bad++; $display("FAIL tmo_done_pulses got=%0d want=1", done_cnt); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", err_timeout); end
      total++; if (done_at - run_at != 16) begin bad++; $display("FAIL tmo_latency got=%0d want=16", done_at - run_at); end
`else
      total++; if (done_cnt != 0) begin bad++; $display("FAIL wait_done_pulses got=%0d want=0", done_cnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wait_busy got=%b want=1", busy); end
      total++; if (fir_stop !== 1'b1) begin bad++; $display("FAIL wait_fir_stop got=%b want=1", fir_stop); end
`endif
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; frame_len = '0;
      s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
      fir_next = 1'b0; fir_out = '0; fir_ready = 1'b0;
      #2;
      test_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_basic();
      test_underrun();
      test_overflow();
      test_extra();
      test_mid_reset();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
